// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the branch-mode and FSM state encodings plus the branch LUT power-on contents.
package pc_pkg;

  typedef enum logic [1:0] {
    REL_IMM = 2'b00,
    REL_LUT = 2'b01,
    ABS_LUT = 2'b10,
    RSVD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int LUT_DEF_0    = -5;
  localparam int LUT_DEF_1    = 20;
  localparam int LUT_DEF_2    = -1;
  localparam int LUT_DEF_LAST = -120;

  // Reset value of LUT entry idx; every entry without a named default is zero.
  function automatic int lut_default(input int idx, input int depth);
    int val;
    val = 0;
    if (idx == 0)              val = LUT_DEF_0;
    else if (idx == 1)         val = LUT_DEF_1;
    else if (idx == 2)         val = LUT_DEF_2;
    else if (idx == depth - 1) val = LUT_DEF_LAST;
    return val;
  endfunction

endpackage

// File: rtl/pc_seq_unit_ret_stack.sv
// Return-address LIFO built as a shift register: the top of stack is always entry 0.
// A push while full is dropped and a pop while empty is ignored; clr empties it.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  entries_q [DEPTH];
  logic [W-1:0]  entries_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign top     = entries_q[0];
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (clr) begin
      count_d = '0;
    end else if (do_push) begin
      entries_d[0] = din;
      for (int i = 1; i < DEPTH; i++) entries_d[i] = entries_q[i-1];
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = entries_q[i+1];
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program-counter sequencer: run/done FSM, next-PC mux with relative/absolute
// jumps through a writable branch LUT, and calls/returns through a small return stack.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int D         = 12,
  parameter int LUT_DEPTH = 16,
  parameter int SEL_W     = $clog2(LUT_DEPTH),
  parameter int RS_DEPTH  = 4,
  parameter int SP_W      = $clog2(RS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_en,
  input  logic             br_taken,
  input  logic             call,
  input  logic             ret,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             lut_we,
  input  logic [SEL_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  output logic [D-1:0]     prog_ctr,
  output logic             busy,
  output logic             done,
  output logic [SP_W-1:0]  sp,
  output logic             err_ovf,
  output logic             err_unf
);

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_unf_q, err_unf_d;
  logic [D-1:0]   lut_q [LUT_DEPTH];
  logic [D-1:0]   lut_d [LUT_DEPTH];

  logic [D-1:0]   pc_inc;
  logic [D-1:0]   sel_sext;
  logic [D-1:0]   lut_rd;
  logic [D-1:0]   target;
  logic           rs_push, rs_pop, rs_clr;
  logic [D-1:0]   rs_top;
  logic           rs_full, rs_empty;
  logic [SP_W-1:0] rs_count;

  ret_stack #(
    .DEPTH (RS_DEPTH),
    .W     (D),
    .CW    (SP_W)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .clr   (rs_clr),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (pc_inc),
    .top   (rs_top),
    .full  (rs_full),
    .empty (rs_empty),
    .count (rs_count)
  );

  // LUT reads come from the stored array, so a same-cycle write is seen one cycle later.
  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d[lut_waddr] = lut_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= D'(lut_default(i, LUT_DEPTH));
    end else begin
      lut_q <= lut_d;
    end
  end

  assign pc_inc   = pc_q + D'(1);
  assign sel_sext = {{(D-SEL_W){sel[SEL_W-1]}}, sel};
  assign lut_rd   = lut_q[sel];

  always_comb begin
    target = pc_inc;
    case (mode_t'(mode))
      REL_IMM: target = pc_q + sel_sext;
      REL_LUT: target = pc_q + lut_rd;
      ABS_LUT: target = lut_rd;
      default: target = pc_inc;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    rs_push   = 1'b0;
    rs_pop    = 1'b0;
    rs_clr    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = '0;
          err_ovf_d = 1'b0;
          err_unf_d = 1'b0;
          rs_clr    = 1'b1;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
        end else if (!stall) begin
          // Priority: ret, then call, then taken branch, else sequential.
          if (ret) begin
            if (!rs_empty) begin
              pc_d   = rs_top;
              rs_pop = 1'b1;
            end else begin
              pc_d      = pc_inc;
              err_unf_d = 1'b1;
            end
          end else if (call) begin
            pc_d = target;
            if (!rs_full) rs_push   = 1'b1;
            else          err_ovf_d = 1'b1;
          end else if (br_en && br_taken) begin
            pc_d = target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign prog_ctr = pc_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sp       = rs_count;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed steps then random traffic, all checked against a
// queue-based behavioural model of the sequencer.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, halt, br_en, br_taken, call, ret;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic        lut_we;
  logic [3:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic [11:0] prog_ctr;
  logic        busy, done;
  logic [2:0]  sp;
  logic        err_ovf, err_unf;

  int total = 0;
  int bad   = 0;

  int m_pc;
  int m_state;  // 0 idle, 1 run, 2 done
  int m_stack[$];
  bit m_ovf, m_unf;
  int m_lut[16];

  pc_seq_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .halt      (halt),
    .br_en     (br_en),
    .br_taken  (br_taken),
    .call      (call),
    .ret       (ret),
    .mode      (mode),
    .sel       (sel),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .prog_ctr  (prog_ctr),
    .busy      (busy),
    .done      (done),
    .sp        (sp),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sext4(input logic [3:0] s);
    int v;
    v = int'(s);
    if (v >= 8) v = v - 16;
    return v;
  endfunction

  task automatic model_edge();
    int tgt, rd, inc;
    if (reset) begin
      m_state = 0;
      m_pc    = 0;
      m_stack.delete();
      m_ovf   = 0;
      m_unf   = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
      m_lut[0]  = (-5)   & 12'hFFF;
      m_lut[1]  = 20;
      m_lut[2]  = (-1)   & 12'hFFF;
      m_lut[15] = (-120) & 12'hFFF;
      return;
    end
    rd  = m_lut[sel];
    inc = (m_pc + 1) & 12'hFFF;
    case (mode)
      2'd0:    tgt = (m_pc + sext4(sel)) & 12'hFFF;
      2'd1:    tgt = (m_pc + rd) & 12'hFFF;
      2'd2:    tgt = rd;
      default: tgt = inc;
    endcase
    if (m_state != 1) begin
      if (start) begin
        m_state = 1;
        m_pc    = 0;
        m_stack.delete();
        m_ovf   = 0;
        m_unf   = 0;
      end
    end else if (halt) begin
      m_state = 2;
    end else if (!stall) begin
      if (ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = inc; m_unf = 1; end
      end else if (call) begin
        if (m_stack.size() < 4) m_stack.push_back(inc);
        else m_ovf = 1;
        m_pc = tgt;
      end else if (br_en && br_taken) begin
        m_pc = tgt;
      end else begin
        m_pc = inc;
      end
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("pc", 32'(prog_ctr), 32'(m_pc));
    check("busy", 32'(busy), 32'(m_state == 1));
    check("done", 32'(done), 32'(m_state == 2));
    check("sp", 32'(sp), 32'(m_stack.size()));
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
    check("err_unf", 32'(err_unf), 32'(m_unf));
  endtask

  task automatic quiet();
    reset = 0; start = 0; stall = 0; halt = 0; br_en = 0; br_taken = 0;
    call = 0; ret = 0; mode = 2'd0; sel = 4'd0;
    lut_we = 0; lut_waddr = 4'd0; lut_wdata = 12'd0;
  endtask

  initial begin
    int ret_exp[5];
    ret_exp = '{8, 6, 4, 2, 3};
    m_pc = 0; m_state = 0; m_ovf = 0; m_unf = 0;
    quiet();

    // reset state
    reset = 1;
    tick();
    check("reset_pc", 32'(prog_ctr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // start then sequential increments
    reset = 0; start = 1;
    tick();
    start = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i <= 5) check("seq_pc", 32'(prog_ctr), 32'(i));
    end

    // REL_LUT taken branch with lut[0] = -5 from PC 10
    br_en = 1; br_taken = 1; mode = 2'd1; sel = 4'd0;
    tick();
    check("rel_lut_taken", 32'(prog_ctr), 32'd5);
    mode = 2'd0; sel = 4'd4;
    tick();
    br_en = 0;
    tick();
    br_en = 1; br_taken = 0; mode = 2'd1; sel = 4'd0;
    tick();
    check("br_not_taken", 32'(prog_ctr), 32'd11);
    br_taken = 1; mode = 2'd0; sel = 4'b1000;
    tick();
    check("rel_imm_neg8", 32'(prog_ctr), 32'd3);
    sel = 4'b1110;
    tick();
    check("rel_imm_neg2", 32'(prog_ctr), 32'd1);

    // LUT write: same-cycle read sees old value, next cycle sees new
    lut_we = 1; lut_waddr = 4'd5; lut_wdata = 12'h123; mode = 2'd2; sel = 4'd5;
    tick();
    check("lut_same_cycle", 32'(prog_ctr), 32'd0);
    lut_we = 0;
    tick();
    check("lut_abs_new", 32'(prog_ctr), 32'h123);

    // wrap-around
    lut_we = 1; lut_waddr = 4'd6; lut_wdata = 12'hFFE; br_en = 0;
    tick();
    lut_we = 0; br_en = 1; mode = 2'd2; sel = 4'd6;
    tick();
    check("abs_ffe", 32'(prog_ctr), 32'hFFE);
    mode = 2'd0; sel = 4'd3;
    tick();
    check("wrap", 32'(prog_ctr), 32'h001);

    // five calls overflow the 4-deep stack; jumps still taken
    br_en = 0; call = 1; mode = 2'd0; sel = 4'd2;
    for (int i = 0; i < 5; i++) tick();
    check("call_pc", 32'(prog_ctr), 32'd11);
    check("call_sp", 32'(sp), 32'd4);
    check("call_ovf", 32'(err_ovf), 32'd1);
    call = 0; ret = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ret_pc", 32'(prog_ctr), 32'(ret_exp[i]));
    end
    check("ret_unf", 32'(err_unf), 32'd1);

    // halt with stall freezes PC; DONE ignores control inputs
    ret = 0; halt = 1; stall = 1;
    tick();
    check("halt_done", 32'(done), 32'd1);
    check("halt_pc", 32'(prog_ctr), 32'd3);
    halt = 0; stall = 0; call = 1; br_en = 1; br_taken = 1;
    tick();
    tick();
    quiet();
    start = 1;
    tick();
    check("restart_pc", 32'(prog_ctr), 32'd0);
    check("restart_ovf", 32'(err_ovf), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 29) == 0);
      halt      = ($urandom_range(0, 39) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      ret       = ($urandom_range(0, 5) == 0);
      call      = ($urandom_range(0, 5) == 0);
      br_en     = 1'($urandom_range(0, 1));
      br_taken  = 1'($urandom_range(0, 1));
      mode      = 2'($urandom_range(0, 3));
      sel       = 4'($urandom_range(0, 15));
      lut_we    = ($urandom_range(0, 7) == 0);
      lut_waddr = 4'($urandom_range(0, 15));
      lut_wdata = 12'($urandom_range(0, 4095));
      tick();
    end

    // reset mid-run restores LUT defaults
    quiet();
    start = 1;
    tick();
    start = 0;
    tick();
    reset = 1;
    tick();
    check("midrun_reset_pc", 32'(prog_ctr), 32'd0);
    check("midrun_reset_busy", 32'(busy), 32'd0);
    reset = 0; start = 1;
    tick();
    start = 0; br_en = 1; br_taken = 1; mode = 2'd1; sel = 4'd1;
    tick();
    check("lut1_default", 32'(prog_ctr), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Program-counter sequencer for the core fetch stage. It holds the PC register and produces the next PC for each cycle. Next PC is one of: sequential increment, relative jump (sign-extended immediate or programmable LUT offset), absolute jump (LUT entry), call, or return. It adds a run/done state machine, a writable branch LUT and a small return-address stack.

Parameters:
D, 12, PC and offset width in bits; must be at least 8.
LUT_DEPTH, 16, number of branch LUT entries; must be a power of 2.
SEL_W, $clog2(LUT_DEPTH), width of the select/immediate field.
RS_DEPTH, 4, number of return-stack entries.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  pulse: begin execution from PC 0
stall  in  1  hold PC and stack this cycle
halt  in  1  stop execution (DONE state)
br_en  in  1  conditional branch instruction
br_taken  in  1  branch condition result
call  in  1  unconditional jump, pushes return address
ret  in  1  pop return address into PC
mode  in  2  00 REL_IMM, 01 REL_LUT, 10 ABS_LUT, 11 reserved
sel  in  SEL_W  immediate value (REL_IMM) or LUT index
lut_we  in  1  LUT write enable
lut_waddr  in  SEL_W  LUT write index
lut_wdata  in  D  LUT write data (signed offset or absolute address)
prog_ctr  out  D  current PC
busy  out  1  state == RUN
done  out  1  state == DONE
sp  out  $clog2(RS_DEPTH+1)  return-stack occupancy
err_ovf  out  1  sticky: call attempted while stack full
err_unf  out  1  sticky: ret attempted while stack empty

Behaviour:
- Reset, synchronous, highest priority:
  - state=IDLE, prog_ctr=0, sp=0, err_ovf=0, err_unf=0.
  - LUT entries load defaults: [0]=-5, [1]=+20, [2]=-1, [LUT_DEPTH-1]=-120; all other entries 0.
- FSM transitions:
  - IDLE: start -> RUN.
  - RUN: halt -> DONE.
  - DONE: start -> RUN.
  - start in IDLE or DONE forces prog_ctr=0 and clears sp, err_ovf and err_unf in the same edge.
  - start in RUN is ignored.
- In IDLE and DONE, prog_ctr holds; all control inputs except start and lut_we are ignored.
- In RUN with halt=1: state goes to DONE; prog_ctr and the stack are unchanged that edge, even when stall=1.
- In RUN with stall=1 and halt=0: prog_ctr, stack and error flags all hold.
- Target computation (combinational):
  - REL_IMM: prog_ctr + sign-extend(sel).
  - REL_LUT: prog_ctr + lut[sel].
  - ABS_LUT: lut[sel].
  - All sums are modulo 2^D, so wrap-around is legal.
  - Reserved mode: the target is prog_ctr+1.
- Next-PC priority in RUN, not stalled: ret > call > (br_en & br_taken) > prog_ctr+1.
  - ret, sp>0: prog_ctr <= top of stack; sp decrements.
  - ret, sp==0: prog_ctr <= prog_ctr+1; err_unf <= 1.
  - call, sp<RS_DEPTH: push prog_ctr+1; sp increments; prog_ctr <= target.
  - call, sp==RS_DEPTH: push dropped; err_ovf <= 1; jump still taken.
  - br_en with br_taken=0: prog_ctr <= prog_ctr+1.
- Latency: one cycle from a control input to the new prog_ctr. No bubbles.
- LUT port:
  - Written at the edge when lut_we=1, in any state except during reset.
  - Read is combinational from the stored array.
  - A write and a read of the same index in one cycle: the read sees the old value; the new value is visible next cycle.
- Error flags stay set until reset or start.

Decomposition:
- Shared package pc_pkg holds:
  - mode enum: REL_IMM, REL_LUT, ABS_LUT, RSVD.
  - state enum: IDLE, RUN, DONE.
  - LUT default constants.
- One sub-module, ret_stack: parametrised LIFO (RS_DEPTH x D) with push, pop, full, empty and count.
- Next-PC mux and FSM stay in the top level.

Test Plan:
1. Reset, then start, then 5 idle cycles -> prog_ctr 0,1,2,3,4,5; busy=1; done=0.
2. At PC=10, mode=REL_LUT, sel=0, br_en=1, br_taken=1 -> next PC 5. Repeat with br_taken=0 -> PC 11. At PC=3, mode=REL_IMM, sel=4'b1110 -> PC 1.
3. Write lut[5]=12'h123, then ABS_LUT sel=5 in the next cycle -> PC 0x123. Write and read index 5 in the same cycle -> old value used.
4. At PC 0xFFE, REL_IMM sel=+3 -> PC 0x001 (wrap-around).
5. Five calls with RS_DEPTH=4 -> sp saturates at 4; err_ovf=1 after the 5th call; the jump is still taken. Then five rets -> first four pop addresses in LIFO order; the fifth gives PC+1 and err_unf=1.
6. halt together with stall in RUN -> done=1 and PC frozen. Then start -> PC=0, flags cleared, busy=1. Reset asserted mid-RUN -> IDLE, PC=0, LUT defaults restored (lut[1]=+20).
